// File: rtl/seq_bit_serializer.sv
// Parallel-in, serial-out stage feeding the 10110 sequence detector's in_seq.
// Streams back-to-back words gap-free; drives IDLE_BIT between words.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no word in flight; ser_out = IDLE_BIT, ready for a new word
//  SHIFT | bit bit_cnt of shreg's word is on ser_out; last bit reopens ready
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRELAST_IDX = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;

    logic             last_bit;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shreg_shifted;

    assign last_bit   = (bit_cnt == LAST_IDX);
    assign load_ready = !rst && (state == IDLE || last_bit);
    assign accept     = load_valid && load_ready;

    // shreg keeps the bit currently on ser_out at its outgoing end, so the
    // following bit always sits one position inward.
    assign first_bit     = MSB_FIRST ? par_in[WIDTH-1] : par_in[0];
    assign next_bit      = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
    assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            shreg     <= par_in;
            bit_cnt   <= '0;
            ser_out   <= first_bit;
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            word_done <= 1'b0;
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state     <= IDLE;
                ser_out   <= IDLE_BIT;
                ser_valid <= 1'b0;
                busy      <= 1'b0;
                word_done <= 1'b0;
            end else begin
                shreg     <= shreg_shifted;
                ser_out   <= next_bit;
                bit_cnt   <= bit_cnt + CW'(1);
                word_done <= (bit_cnt == PRELAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: three instances (MSB-first, LSB-first, idle-high)
// share one stimulus stream and are compared cycle by cycle against a word scoreboard.
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] par_in;
    logic       load_valid;
    logic [2:0] load_ready, ser_out, ser_valid, busy, word_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid),
        .load_ready(load_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .busy(busy[0]), .word_done(word_done[0]));

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid),
        .load_ready(load_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .busy(busy[1]), .word_done(word_done[1]));

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_idle1 (
        .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid),
        .load_ready(load_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
        .busy(busy[2]), .word_done(word_done[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words in flight live in the scoreboard queue; m_cnt is the bit index shown.
    logic [7:0] sb[$];
    bit         m_busy  = 1'b0;
    int         m_cnt   = 0;
    bit         acc     = 1'b0;
    int         cyc     = 0;
    int         wd_seen = 0;
    logic [4:0] hist    = '0;

    always @(posedge clk) begin
        logic [7:0] w;
        logic       exp_bit;
        logic       exp_rdy;
        acc = 1'b0;
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            sb.delete();
        end else if (load_valid && (!m_busy || m_cnt == 7)) begin
            if (m_busy) void'(sb.pop_front());
            sb.push_back(par_in);
            m_busy = 1'b1;
            m_cnt  = 0;
            acc    = 1'b1;
        end else if (m_busy) begin
            if (m_cnt == 7) begin
                void'(sb.pop_front());
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
        #1;
        exp_rdy = !rst && (!m_busy || m_cnt == 7);
        w = (m_busy && sb.size() != 0) ? sb[0] : 8'h00;
        if (m_busy) chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        for (int c = 0; c < 3; c++) begin
            if (m_busy) exp_bit = (c == 1) ? w[m_cnt] : w[7 - m_cnt];
            else        exp_bit = (c == 2);
            chk($sformatf("ser_out[%0d]", c), 32'(ser_out[c]), 32'(exp_bit));
            chk($sformatf("ser_valid[%0d]", c), 32'(ser_valid[c]), 32'(m_busy));
            chk($sformatf("busy[%0d]", c), 32'(busy[c]), 32'(m_busy));
            chk($sformatf("word_done[%0d]", c), 32'(word_done[c]), 32'(m_busy && m_cnt == 7));
            chk($sformatf("load_ready[%0d]", c), 32'(load_ready[c]), 32'(exp_rdy));
        end
        if (word_done[0]) wd_seen++;
        hist = {hist[3:0], ser_out[0]};
    end

    task automatic send(input logic [7:0] w, output int acc_at);
        par_in     = w;
        load_valid = 1'b1;
        acc_at     = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (acc) begin
                acc_at = cyc;
                break;
            end
        end
        if (acc_at < 0) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        load_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int c1, c2, wd0;
        rst        = 1'b1;
        load_valid = 1'b1;
        par_in     = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("ready_after_rst", 32'(load_ready), 32'h7);

        // single word, then detector-side view of the first five bits
        idle_cycles(2);
        send(8'b1011_0000, c1);
        load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("det_10110", 32'(hist), 32'b10110);
        idle_cycles(6);

        // back-to-back with load_valid held
        wd0 = wd_seen;
        send(8'hB5, c1);
        send(8'h6C, c2);
        load_valid = 1'b0;
        chk("b2b_gap", 32'(c2 - c1), 32'd8);
        idle_cycles(10);
        chk("b2b_word_done", 32'(wd_seen - wd0), 32'd2);

        // LSB-first reference word
        send(8'b0000_1101, c1);
        idle_cycles(10);

        // reset after the third bit of 8'hFF
        wd0 = wd_seen;
        send(8'hFF, c1);
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_no_done", 32'(wd_seen - wd0), 32'd0);
        send(8'h81, c1);
        idle_cycles(10);

        // hold-off: request arrives at bit 2 of a word in flight
        send(8'hA5, c1);
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        send(8'h3C, c2);
        load_valid = 1'b0;
        chk("holdoff_accept", 32'(c2 - c1), 32'd8);
        idle_cycles(12);

        // random words with random gaps
        for (int k = 0; k < 6; k++) begin
            send(8'($urandom), c1);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 10));
        end
        idle_cycles(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
